// File: rtl/locked_register_bank.sv
// Bank of NUM_REGS registers with sticky per-register write locks and a two-key debug override.
// Optional saturating lock-violation counter enabled by `define LOCKED_REG_VIOLATION_CNT_EN.
module locked_register_bank #(
  parameter int               WIDTH       = 16,
  parameter int               NUM_REGS    = 4,
  parameter int               ADDR_W      = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] DBG_KEY_A   = 16'hC0DE,
  parameter logic [WIDTH-1:0] DBG_KEY_B   = 16'h5AFE,
  parameter int               VIOL_W      = 8
) (
  input  logic                Clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic                lock_en,
  input  logic [ADDR_W-1:0]   lock_addr,
  input  logic                lock_all,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [WIDTH-1:0]    rd_data,
  input  logic                scan_mode,
  input  logic                debug_req,
  input  logic [WIDTH-1:0]    debug_key,
  output logic                debug_active,
  output logic                wr_ack,
  output logic                wr_err,
  output logic [NUM_REGS-1:0] lock_status,
`ifdef LOCKED_REG_VIOLATION_CNT_EN
  output logic [VIOL_W-1:0]   viol_count,
`endif
  output logic [1:0]          debug_state
);

  if (NUM_REGS > 2**ADDR_W || VIOL_W < 1) begin : g_bad_params
    $error("locked_register_bank: NUM_REGS must fit in ADDR_W and VIOL_W must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_ACTIVE = 2'd2
  } dbg_state_t;

  localparam logic [ADDR_W:0] NREGS = NUM_REGS[ADDR_W:0];

  logic [WIDTH-1:0]    r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_lock;
  logic [WIDTH-1:0]    r_rd_data;
  logic                r_wr_ack;
  logic                r_wr_err;
  dbg_state_t          r_state;
  logic                r_dbg_active;

  logic                w_wr_in_range;
  logic                w_lock_bit;
  logic                w_lock_hit;
  logic                w_override;
  logic                w_wr_accept;
  logic                w_lock_viol;
  logic [NUM_REGS-1:0] w_lock_set;
  logic [WIDTH-1:0]    w_rd_val;

  // Override is masked combinationally so scan_mode blocks it in the very cycle it rises.
  assign w_override    = r_dbg_active & ~scan_mode;
  assign w_wr_in_range = ({1'b0, wr_addr} < NREGS);
  assign w_lock_hit    = lock_all | (lock_en & (lock_addr == wr_addr));
  assign w_wr_accept   = wr_en & w_wr_in_range & ((~w_lock_bit & ~w_lock_hit) | w_override);
  assign w_lock_viol   = wr_en & w_wr_in_range & ~w_wr_accept;

  always_comb begin
    w_lock_bit = 1'b0;
    w_lock_set = '0;
    w_rd_val   = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_addr == ADDR_W'(i)) w_lock_bit = r_lock[i];
      if (rd_addr == ADDR_W'(i)) w_rd_val = r_regs[i];
      w_lock_set[i] = lock_all | (lock_en & (lock_addr == ADDR_W'(i)));
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VALUE;
      r_lock    <= '0;
      r_rd_data <= '0;
      r_wr_ack  <= 1'b0;
      r_wr_err  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wr_accept && (wr_addr == ADDR_W'(i))) r_regs[i] <= wr_data;
      end
      r_lock    <= r_lock | w_lock_set;
      r_rd_data <= w_rd_val;
      r_wr_ack  <= w_wr_accept;
      r_wr_err  <= wr_en & ~w_wr_accept;
    end
  end

  // Debug unlock: KEY_A then KEY_B on consecutive cycles, held by debug_req.
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_dbg_active <= 1'b0;
    end else if (scan_mode) begin
      r_state      <= ST_IDLE;
      r_dbg_active <= 1'b0;
    end else begin
      r_dbg_active <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (debug_req && (debug_key == DBG_KEY_A)) r_state <= ST_ARMED;
        end
        ST_ARMED: begin
          if (debug_req && (debug_key == DBG_KEY_B)) begin
            r_state      <= ST_ACTIVE;
            r_dbg_active <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ACTIVE: begin
          if (debug_req) r_dbg_active <= 1'b1;
          else           r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef LOCKED_REG_VIOLATION_CNT_EN
  logic [VIOL_W-1:0] r_viol;

  always_ff @(posedge Clk) begin
    if (reset)                          r_viol <= '0;
    else if (w_lock_viol && (r_viol != '1)) r_viol <= r_viol + 1'b1;
  end

  assign viol_count = r_viol;
`else
  logic w_unused_viol;
  assign w_unused_viol = w_lock_viol;
`endif

  assign rd_data      = r_rd_data;
  assign wr_ack       = r_wr_ack;
  assign wr_err       = r_wr_err;
  assign lock_status  = r_lock;
  assign debug_active = r_dbg_active;
  assign debug_state  = r_state;

endmodule

// File: tb/tb_locked_register_bank.sv
// Directed bench for locked_register_bank (NUM_REGS=3 so address 3 is out of range, VIOL_W=2 to reach saturation).
// Write responses and read data are checked by a monitor against expected queues filled by the driver.
module tb_locked_register_bank;
  localparam int WIDTH  = 16;
  localparam int NR     = 3;
  localparam int ADDR_W = 2;
  localparam int VIOL_W = 2;

  logic              Clk;
  logic              reset;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              lock_en;
  logic [ADDR_W-1:0] lock_addr;
  logic              lock_all;
  logic [ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]  rd_data;
  logic              scan_mode;
  logic              debug_req;
  logic [WIDTH-1:0]  debug_key;
  logic              debug_active;
  logic              wr_ack;
  logic              wr_err;
  logic [NR-1:0]     lock_status;
  logic [1:0]        debug_state;
`ifdef LOCKED_REG_VIOLATION_CNT_EN
  logic [VIOL_W-1:0] viol_count;
`endif

  locked_register_bank #(
    .WIDTH(WIDTH), .NUM_REGS(NR), .ADDR_W(ADDR_W), .VIOL_W(VIOL_W)
  ) u_dut (
    .Clk(Clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .lock_en(lock_en), .lock_addr(lock_addr), .lock_all(lock_all),
    .rd_addr(rd_addr), .rd_data(rd_data), .scan_mode(scan_mode),
    .debug_req(debug_req), .debug_key(debug_key), .debug_active(debug_active),
    .wr_ack(wr_ack), .wr_err(wr_err), .lock_status(lock_status),
`ifdef LOCKED_REG_VIOLATION_CNT_EN
    .viol_count(viol_count),
`endif
    .debug_state(debug_state)
  );

  // Clock and reset defaults.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic        rd_chk   = 1'b0;
  logic        exp_wr_q [$];
  logic [WIDTH-1:0] exp_rd_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_viol(input logic [31:0] exp);
`ifdef LOCKED_REG_VIOLATION_CNT_EN
    check("viol_count", 32'(viol_count), exp);
`endif
  endtask

  // Driver tasks: inputs are set after a falling edge; tick() lets the next rising edge consume them.
  task automatic tick();
    @(negedge Clk);
    wr_en    = 1'b0;
    lock_en  = 1'b0;
    lock_all = 1'b0;
    rd_chk   = 1'b0;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d, input logic ok);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    exp_wr_q.push_back(ok);
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] expv);
    rd_addr = a;
    rd_chk  = 1'b1;
    exp_rd_q.push_back(expv);
  endtask

  // Monitor: write response pulses and tagged read data, sampled 1 time unit after the edge.
  always @(posedge Clk) begin
    logic take_rd;
    logic e_ok;
    logic [WIDTH-1:0] e_rd;
    take_rd = rd_chk;
    #1;
    if (wr_ack && wr_err) check("ack_err_exclusive", 32'd1, 32'd0);
    if (wr_ack || wr_err) begin
      if (exp_wr_q.size() == 0) begin
        check("unexpected_wr_resp", {30'd0, wr_ack, wr_err}, 32'd0);
      end else begin
        e_ok = exp_wr_q.pop_front();
        check("wr_resp_ack", 32'(wr_ack), 32'(e_ok));
      end
    end
    if (take_rd) begin
      if (exp_rd_q.size() == 0) begin
        check("unexpected_rd", 32'd1, 32'd0);
      end else begin
        e_rd = exp_rd_q.pop_front();
        check("rd_data", 32'(rd_data), 32'(e_rd));
      end
    end
  end

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    lock_en = 1'b0; lock_addr = '0; lock_all = 1'b0; rd_addr = '0;
    scan_mode = 1'b0; debug_req = 1'b0; debug_key = '0;
    tick(); tick();
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_wr_ack", 32'(wr_ack), 32'd0);
    check("rst_wr_err", 32'(wr_err), 32'd0);
    check("rst_lock_status", 32'(lock_status), 32'd0);
    check("rst_debug_active", 32'(debug_active), 32'd0);
    check("rst_debug_state", 32'(debug_state), 32'd0);
    check_viol(32'd0);
    reset = 1'b0;

    // Plain write then read-back.
    wr(2'd1, 16'h1234, 1'b1); tick();
    rd(2'd1, 16'h1234); tick();
    check("lock_status_none", 32'(lock_status), 32'd0);

    // Locked register rejects writes.
    lock_en = 1'b1; lock_addr = 2'd1; tick();
    wr(2'd1, 16'hFFFF, 1'b0); tick();
    rd(2'd1, 16'h1234); tick();
    check("lock_status_r1", 32'(lock_status), 32'b010);
    check_viol(32'd1);

    // Same-cycle lock_all beats the write.
    wr(2'd2, 16'h5555, 1'b1); tick();
    lock_all = 1'b1; wr(2'd2, 16'hAAAA, 1'b0); tick();
    rd(2'd2, 16'h5555); tick();
    check("lock_status_all", 32'(lock_status), 32'b111);
    check_viol(32'd2);

    // Out-of-range write/read: rejected, not counted, reads zero.
    wr(2'd3, 16'h7777, 1'b0); tick();
    rd(2'd3, 16'h0000); tick();
    check_viol(32'd2);

    // Correct key pair grants override.
    debug_req = 1'b1; debug_key = 16'hC0DE; tick();
    check("dbg_armed_state", 32'(debug_state), 32'd1);
    check("dbg_armed_inactive", 32'(debug_active), 32'd0);
    debug_key = 16'h5AFE; tick();
    check("dbg_active", 32'(debug_active), 32'd1);
    wr(2'd1, 16'hBEEF, 1'b1); tick();
    rd(2'd1, 16'hBEEF); tick();
    scan_mode = 1'b1; wr(2'd1, 16'h0001, 1'b0); tick();
    check("dbg_scan_revoke", 32'(debug_active), 32'd0);
    check("dbg_scan_idle", 32'(debug_state), 32'd0);
    check_viol(32'd3);
    rd(2'd1, 16'hBEEF); tick();
    scan_mode = 1'b0; debug_req = 1'b0;
    check("lock_sticky_after_dbg", 32'(lock_status), 32'b111);

    // Dropping debug_req leaves ACTIVE.
    debug_req = 1'b1; debug_key = 16'hC0DE; tick();
    debug_key = 16'h5AFE; tick();
    check("dbg_active_again", 32'(debug_active), 32'd1);
    debug_req = 1'b0; tick();
    check("dbg_drop_req", 32'(debug_active), 32'd0);

    // Wrong second key returns to IDLE; locked write still rejected; counter saturates.
    debug_req = 1'b1; debug_key = 16'hC0DE; tick();
    debug_key = 16'h0000; tick();
    check("dbg_wrong_key_state", 32'(debug_state), 32'd0);
    check("dbg_wrong_key_active", 32'(debug_active), 32'd0);
    debug_req = 1'b0;
    wr(2'd0, 16'h1111, 1'b0); tick();
    rd(2'd0, 16'h0000); tick();
    check_viol(32'd3);

    // Reset mid-sequence with a write in flight: no response, state cleared.
    reset = 1'b1; wr_en = 1'b1; wr_addr = 2'd0; wr_data = 16'h2222; tick();
    reset = 1'b0;
    check("mid_rst_lock_status", 32'(lock_status), 32'd0);
    check("mid_rst_debug_active", 32'(debug_active), 32'd0);
    check_viol(32'd0);
    rd(2'd0, 16'h0000); tick();
    rd(2'd1, 16'h0000); tick();
    rd(2'd2, 16'h0000); tick();
    wr(2'd1, 16'h4321, 1'b1); tick();
    rd(2'd1, 16'h4321); tick();

    tick(); tick();
    check("wr_q_drained", 32'(exp_wr_q.size()), 32'd0);
    check("rd_q_drained", 32'(exp_rd_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
